// File: rtl/count_sequencer_if.sv
// Key, rate and limit inputs plus counter/strobe outputs of count_sequencer.
// Purely combinational wiring; there is no backpressure on any signal.
interface count_sequencer_if;
  logic       key_run_n;
  logic       key_step_n;
  logic [1:0] rate;
  logic [8:0] max_count;
  logic [8:0] day_count;
  logic       count_en;
  logic       wrap;
  logic       latch;
  logic       running;

  modport master (
    output key_run_n, key_step_n, rate, max_count,
    input  day_count, count_en, wrap, latch, running
  );

  modport slave (
    input  key_run_n, key_step_n, rate, max_count,
    output day_count, count_en, wrap, latch, running
  );
endinterface

// File: rtl/count_sequencer.sv
// Debounced run/step keys drive a 1..limit day counter; key press to event is 2+DEBOUNCE clk.
// day_count/count_en/wrap are registered, latch follows one clk later; no backpressure.
module count_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int DEBOUNCE = 500000
) (
  input  logic            clk,
  input  logic            reset_n,
  count_sequencer_if.slave bus
);

  localparam int DB_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam int PW   = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [31:0]     DIV     = 32'(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  // Bit 0 is the run key, bit 1 the step key.
  logic [1:0]      keys;
  logic [1:0]      sync1, sync2, deb, ev;
  logic [DB_W-1:0] db_cnt [2];

  state_t          state, next_state;
  logic [PW-1:0]   presc;
  logic [31:0]     period;
  logic [PW-1:0]   period_m1;
  logic [8:0]      limit;
  logic [8:0]      day;
  logic            run_ev, step_ev, step_adv, tick, advance;
  logic            count_en_q, wrap_q, latch_q, first_q;

  assign keys    = {bus.key_step_n, bus.key_run_n};
  assign run_ev  = ev[0];
  assign step_ev = ev[1];

  // A new level is accepted only after DEBOUNCE consecutive differing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 2'b11;
      sync2     <= 2'b11;
      deb       <= 2'b11;
      ev        <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        ev[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          deb[i]    <= sync2[i];
          ev[i]     <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    step_adv   = 1'b0;
    case (state)
      IDLE: begin
        if (run_ev)       next_state = RUN;
        else if (step_ev) step_adv   = 1'b1;
      end
      RUN: begin
        if (run_ev) next_state = PAUSE;
      end
      PAUSE: begin
        if (run_ev)       next_state = RUN;
        else if (step_ev) step_adv   = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  assign period    = DIV >> bus.rate;
  assign period_m1 = PW'(period - 32'd1);
  assign tick      = (state == RUN) && !run_ev && (presc >= period_m1);
  assign advance   = tick || step_adv;
  assign limit     = (bus.max_count == 9'd0 || bus.max_count > 9'd366) ? 9'd365 : bus.max_count;

  // Prescaler only runs while staying in RUN, so every RUN entry starts from 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (state == RUN && next_state == RUN) begin
      presc <= tick ? '0 : presc + PW'(1);
    end else begin
      presc <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      day        <= 9'd1;
      count_en_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      count_en_q <= advance;
      wrap_q     <= advance && (day >= limit);
      if (advance) day <= (day >= limit) ? 9'd1 : day + 9'd1;
    end
  end

  // first_q makes the display load the reset value on the first clock after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_q <= 1'b0;
      first_q <= 1'b1;
    end else begin
      latch_q <= count_en_q || first_q;
      first_q <= 1'b0;
    end
  end

  assign bus.day_count = day;
  assign bus.count_en  = count_en_q;
  assign bus.wrap      = wrap_q;
  assign bus.latch     = latch_q;
  assign bus.running   = (state == RUN);

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer with TICK_DIV=8, DEBOUNCE=4.
module tb_count_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  count_sequencer_if bus ();

  count_sequencer #(.TICK_DIV(8), .DEBOUNCE(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int day;
    int wrap;
    int gap;   // cycles since previous count_en or RUN entry; 0 = not checked
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   ref_cyc  = 0;
  int   edges    = 0;
  bit   prev_ce  = 1'b0;
  bit   prev_run = 1'b0;

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic push(int day, int wrap, int gap);
    sb.push_back('{day: day, wrap: wrap, gap: gap});
  endtask

  // Clock edges seen since reset release; the first one must strobe latch.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)      edges <= 0;
    else if (edges < 2) edges <= edges + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    bit   exp_l;
    cyc++;
    if (!reset_n) begin
      prev_ce  = 1'b0;
      prev_run = 1'b0;
    end else begin
      if (bus.running && !prev_run) ref_cyc = cyc;
      exp_l = prev_ce || (edges == 1);
      if (exp_l || bus.latch) check("latch", int'(bus.latch), int'(exp_l));
      if (bus.count_en) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_count_en: day_count %0d, required no advance", bus.day_count);
        end else begin
          e = sb.pop_front();
          check("day_count", int'(bus.day_count), e.day);
          check("wrap", int'(bus.wrap), e.wrap);
          if (e.gap != 0) check("advance_gap", cyc - ref_cyc, e.gap);
        end
        ref_cyc = cyc;
      end else if (bus.wrap) begin
        check("wrap_without_count_en", int'(bus.wrap), 0);
      end
      prev_ce  = bus.count_en;
      prev_run = bus.running;
    end
  end

  task automatic step_n(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press(bit run, bit step, int hold);
    if (run)  bus.key_run_n  = 1'b0;
    if (step) bus.key_step_n = 1'b0;
    step_n(hold);
    bus.key_run_n  = 1'b1;
    bus.key_step_n = 1'b1;
  endtask

  task automatic bounce_step();
    bus.key_step_n = 1'b0; step_n(1);
    bus.key_step_n = 1'b1; step_n(1);
    bus.key_step_n = 1'b0; step_n(8);
    bus.key_step_n = 1'b1;
  endtask

  task automatic wait_empty(string name, int bound);
    int i = 0;
    while (sb.size() != 0 && i < bound) begin
      step_n(1);
      i++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL %s_timeout: %0d advances outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_run_n  = 1'b1;
    bus.key_step_n = 1'b1;
    bus.rate       = 2'd0;
    bus.max_count  = 9'd0;

    // Reset state and the single latch strobe after release.
    step_n(2);
    check("rst_day_count", int'(bus.day_count), 1);
    check("rst_running", int'(bus.running), 0);
    check("rst_count_en", int'(bus.count_en), 0);
    check("rst_wrap", int'(bus.wrap), 0);
    check("rst_latch", int'(bus.latch), 0);
    reset_n = 1'b1;
    step_n(1);
    check("first_latch", int'(bus.latch), 1);
    step_n(1);
    check("latch_once", int'(bus.latch), 0);
    check("idle_running", int'(bus.running), 0);

    // Run at rate 0, then reset mid-RUN at day_count 5.
    push(2, 0, 8); push(3, 0, 8); push(4, 0, 8); push(5, 0, 8);
    press(1'b1, 1'b0, 10);
    check("run_entered", int'(bus.running), 1);
    wait_empty("run_rate0", 100);
    check("run_day5", int'(bus.day_count), 5);
    step_n(2);
    reset_n = 1'b0;
    #1;
    check("midrun_rst_day", int'(bus.day_count), 1);
    check("midrun_rst_running", int'(bus.running), 0);
    step_n(3);
    reset_n = 1'b1;
    step_n(30);
    check("post_rst_day", int'(bus.day_count), 1);
    check("post_rst_running", int'(bus.running), 0);

    // Wrap at max_count 3, then pause.
    bus.max_count = 9'd3;
    push(2, 0, 8); push(3, 0, 8); push(1, 1, 8); push(2, 0, 8);
    press(1'b1, 1'b0, 10);
    wait_empty("wrap3", 100);
    press(1'b1, 1'b0, 10);
    step_n(20);
    check("paused_running", int'(bus.running), 0);
    check("paused_day", int'(bus.day_count), 2);

    // Bouncing step in PAUSE gives one advance; lowered limit wraps on next step.
    push(3, 0, 0);
    bounce_step();
    wait_empty("bounce_step", 50);
    step_n(10);
    check("bounce_day", int'(bus.day_count), 3);
    bus.max_count = 9'd2;
    push(1, 1, 0);
    bounce_step();
    wait_empty("lowered_limit", 50);
    step_n(10);
    check("lowered_limit_day", int'(bus.day_count), 1);

    // Resume RUN from PAUSE; a step press in RUN is ignored.
    bus.max_count = 9'd0;
    push(2, 0, 8); push(3, 0, 8); push(4, 0, 8);
    press(1'b1, 1'b0, 10);
    press(1'b0, 1'b1, 10);
    wait_empty("step_in_run", 100);
    press(1'b1, 1'b0, 10);
    step_n(20);
    check("step_in_run_day", int'(bus.day_count), 4);
    check("step_in_run_paused", int'(bus.running), 0);

    // Simultaneous run+step from IDLE, then rate 3 gives an advance every cycle.
    reset_n = 1'b0;
    step_n(3);
    reset_n = 1'b1;
    step_n(2);
    push(2, 0, 8);
    press(1'b1, 1'b1, 10);
    check("both_running", int'(bus.running), 1);
    check("both_day_unchanged", int'(bus.day_count), 1);
    wait_empty("both_first", 50);
    bus.rate = 2'd3;
    push(3, 0, 1); push(4, 0, 1); push(5, 0, 1); push(6, 0, 1);
    wait_empty("rate3", 20);
    reset_n = 1'b0;
    #1;
    check("rate3_rst_day", int'(bus.day_count), 1);
    check("rate3_rst_running", int'(bus.running), 0);
    step_n(3);
    reset_n = 1'b1;
    bus.rate = 2'd0;
    step_n(20);
    check("final_day", int'(bus.day_count), 1);
    check("final_running", int'(bus.running), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per count tick at rate 0; legal range 8 or more.
REQ-002 Parameter DEBOUNCE, default 500000, clk cycles a key level must be stable before it is accepted; legal range 2 or more.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 key_run_n  input  1  run/pause pushbutton, active-low, asynchronous to clk.
REQ-006 key_step_n  input  1  single-step pushbutton, active-low, asynchronous to clk.
REQ-007 rate  input  2  tick period select: period = TICK_DIV >> rate.
REQ-008 max_count  input  9  last count value before wrap; 0 or >366 means 365.
REQ-009 day_count  output  9  current count, range 1..limit.
REQ-010 count_en  output  1  one-cycle pulse, high in the cycle day_count advances.
REQ-011 wrap  output  1  one-cycle pulse, coincident with count_en when day_count goes limit->1.
REQ-012 latch  output  1  one-cycle pulse one clk after every day_count change, including wrap; downstream display register strobe.
REQ-013 running  output  1  high only in RUN state.

Function
REQ-014 Each key SHALL pass a 2-FF synchronizer, then a debouncer that accepts a new level only after DEBOUNCE consecutive identical synchronized samples.
REQ-015 A press event SHALL be a single-cycle pulse on a debounced 1->0 transition; release generates nothing; held key generates one event.
REQ-016 FSM states: IDLE, RUN, PAUSE.
REQ-017 IDLE: run event -> RUN; step event -> advance once, stay IDLE.
REQ-018 RUN: run event -> PAUSE; step events ignored.
REQ-019 PAUSE: run event -> RUN; step event -> advance once, stay PAUSE.
REQ-020 Run and step events in the same cycle: run event acts, step event discarded.
REQ-021 Prescaler SHALL clear to 0 on every entry into RUN and be held at 0 outside RUN.
REQ-022 In RUN, prescaler increments each cycle; when prescaler >= period-1 it clears and one advance occurs; first advance comes exactly period cycles after entering RUN.
REQ-023 Rate change in RUN takes effect immediately through the >= compare; no extra advances beyond one per compare hit.
REQ-024 Advance: if day_count >= limit then day_count <= 1 and wrap pulses, else day_count <= day_count + 1; limit = max_count if 1..366, else 365.
REQ-025 max_count lowered below current day_count: next advance wraps to 1.
REQ-026 latch SHALL pulse exactly one cycle after each count_en; never otherwise except as in REQ-029.
REQ-027 Arithmetic 9-bit unsigned; day_count never 0 or >366.

Reset
REQ-028 reset_n low SHALL immediately force: state IDLE, day_count 1, count_en 0, wrap 0, running 0, prescaler 0, synchronizers and debounced levels to 1 (released), event pulses 0.
REQ-029 First clk after reset_n release SHALL produce one latch pulse so the display loads day_count = 1.
REQ-030 Reset asserted mid-RUN or mid-debounce abandons all pending events; no advance occurs on release.

Verification (TICK_DIV=8, DEBOUNCE=4)
REQ-031 Reset release -> day_count 1, running 0, single latch pulse on first clk, no count_en.
REQ-032 Run press held 10 cycles, rate 0 -> running 1; count_en every 8 cycles, first 8 cycles after RUN entry; day_count 1,2,3...; latch each 1 cycle after count_en.
REQ-033 max_count 3, RUN -> day_count 1,2,3,1; wrap with the 3->1 count_en only.
REQ-034 PAUSE, step key bouncing 3 toggles in <4 cycles then held low -> exactly one advance; step in RUN -> no extra advance.
REQ-035 Run and step events same cycle from IDLE -> RUN, day_count unchanged; rate 3 -> count_en every 1 cycle.
REQ-036 reset_n pulsed low mid-RUN at day_count 5 -> immediate day_count 1, IDLE, no advance after release.
